mips_wb_trace_buffer: RTL

// Parametrised on-chip writeback trace capture for the MIPS pipeline. It snoops the WB-stage

---
 rtl/mips_wb_trace_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mips_wb_trace_buffer.sv
// Writeback trace capture: circular buffer of retired register writes
// with address trigger, post-trigger depth and a valid/ready drain port.
module mips_wb_trace_buffer #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int RA_W      = 5,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 4,
  parameter int WRAP      = 1,
  parameter int CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         clear,
  input  logic                         trig_en,
  input  logic [RA_W-1:0]              trig_addr,
  input  logic                         wb_valid,
  input  logic [PC_W-1:0]              wb_pc,
  input  logic [RA_W-1:0]              wb_addr,
  input  logic [DATA_W-1:0]            wb_data,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [PC_W+RA_W+DATA_W-1:0]  rd_data,
  output logic [1:0]                   state,
  output logic [$clog2(DEPTH):0]       count,
  output logic [CNT_W-1:0]             retire_cnt,
  output logic [15:0]                  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + RA_W + DATA_W;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] LAST_C = CW'(DEPTH - 1);
  localparam logic [CW-1:0] POST_C = CW'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_POST   = 2'd2,
    S_FROZEN = 2'd3
  } state_e;

  state_e        st_q, st_d;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] post_q, post_d;
  logic [EW-1:0] mem [DEPTH];

  logic cap, pop, hit, full_hit, ctl;

  assign ctl      = start || clear;
  assign cap      = wb_valid && !ctl &&
                    (st_q == S_ARMED || st_q == S_POST);
  assign hit      = trig_en && (wb_addr == trig_addr) &&
                    (st_q == S_ARMED);
  assign full_hit = (WRAP == 0) && (cnt_q == LAST_C);
  assign rd_valid = (st_q == S_FROZEN) && (cnt_q != '0);
  assign pop      = rd_valid && rd_ready && !ctl;
  assign rd_data  = mem[rd_ptr];
  assign state    = st_q;
  assign count    = cnt_q;

  // next state and post-trigger countdown
  always_comb begin
    st_d   = st_q;
    post_d = post_q;
    unique case (1'b1)
      start: begin
        st_d   = S_ARMED;
        post_d = '0;
      end
      clear: begin
        st_d   = S_IDLE;
        post_d = '0;
      end
      cap: begin
        if (st_q == S_POST)
          post_d = post_q - CW'(1);
        if (full_hit)
          st_d = S_FROZEN;
        else if (st_q == S_POST) begin
          if (post_q == CW'(1))
            st_d = S_FROZEN;
        end else if (hit) begin
          if (POST_TRIG == 0)
            st_d = S_FROZEN;
          else begin
            st_d   = S_POST;
            post_d = POST_C;
          end
        end
      end
      default: ;
    endcase
  end

  // state and countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= S_IDLE;
      post_q <= '0;
    end else begin
      st_q   <= st_d;
      post_q <= post_d;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (ctl) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else if (cap) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (cnt_q == FULL_C)
        rd_ptr <= rd_ptr + AW'(1);
      else
        cnt_q <= cnt_q + CW'(1);
    end else if (pop) begin
      rd_ptr <= rd_ptr + AW'(1);
      cnt_q  <= cnt_q - CW'(1);
    end
  end

  // retire and drop statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      drop_cnt   <= '0;
    end else if (start) begin
      retire_cnt <= '0;
      drop_cnt   <= '0;
    end else if (!clear && wb_valid && st_q != S_IDLE) begin
      retire_cnt <= retire_cnt + CNT_W'(1);
      if (st_q == S_FROZEN && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // trace storage, contents survive reset
  always_ff @(posedge clk) begin
    if (cap)
      mem[wr_ptr] <= {wb_pc, wb_addr, wb_data};
  end

endmodule
